// File: rtl/csr_rmw_sequencer.sv
// CSR read-modify-write initiator: takes one decoded CSRRW/RS/RC(I) op from execute,
// drives the strobe/ack CSR bus, applies skip/privilege/read-only rules and returns rd data or illegal.
module csr_rmw_sequencer #(
    parameter int XLEN         = 32,
    parameter int TIMEOUT_CYCS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_rs1_value,
    input  logic [4:0]      req_rs1_idx,
    input  logic [4:0]      req_rd_idx,
    input  logic [1:0]      req_priv,
    output logic            csr_rd_en,
    output logic            csr_wr_en,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic            csr_ack,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_err,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd_idx,
    output logic            rsp_rd_we,
    output logic [XLEN-1:0] rsp_rd_value,
    output logic            rsp_illegal
);

    localparam int CW = $clog2(TIMEOUT_CYCS);
    localparam logic [CW-1:0] LAST_CYC = CW'(TIMEOUT_CYCS - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t          state, state_next;
    logic [1:0]      op_kind;
    logic [11:0]     op_addr;
    logic [XLEN-1:0] op_src;
    logic [4:0]      op_rd;
    logic            op_do_write;
    logic [XLEN-1:0] old_value;
    logic            did_read;
    logic            illegal;
    logic [CW-1:0]   tmo_cnt;

    logic            accept;
    logic [XLEN-1:0] acc_src;
    logic            acc_is_rw;
    logic            acc_do_read;
    logic            acc_do_write;
    logic            acc_illegal;
    logic            timed_out;

    always_comb begin
        accept       = req_valid && (state == IDLE);
        acc_src      = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_value;
        acc_is_rw    = (req_funct3[1:0] == 2'b01);
        acc_do_read  = !(acc_is_rw && (req_rd_idx == 5'd0));
        acc_do_write = acc_is_rw || (req_rs1_idx != 5'd0);
        acc_illegal  = (req_funct3[1:0] == 2'b00) || (req_csr_addr[9:8] > req_priv) ||
                       (acc_do_write && (req_csr_addr[11:10] == 2'b11));
        // An ack on the final allowed strobe cycle still wins over the timeout.
        timed_out    = (tmo_cnt == LAST_CYC) && !csr_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = acc_illegal ? RESP : (acc_do_read ? RD : WR);
            RD: begin
                if (csr_ack)        state_next = (csr_err || !op_do_write) ? RESP : WR;
                else if (timed_out) state_next = RESP;
            end
            WR:   if (csr_ack || timed_out) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_kind     <= '0;
            op_addr     <= '0;
            op_src      <= '0;
            op_rd       <= '0;
            op_do_write <= 1'b0;
            old_value   <= '0;
            did_read    <= 1'b0;
            illegal     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_kind     <= req_funct3[1:0];
                    op_addr     <= req_csr_addr;
                    op_src      <= acc_src;
                    op_rd       <= req_rd_idx;
                    op_do_write <= acc_do_write;
                    old_value   <= '0;
                    did_read    <= 1'b0;
                    illegal     <= acc_illegal;
                    tmo_cnt     <= '0;
                end
                RD: begin
                    if (csr_ack) begin
                        if (csr_err) illegal <= 1'b1;
                        else begin
                            old_value <= csr_rdata;
                            did_read  <= 1'b1;
                        end
                        tmo_cnt <= '0;
                    end else if (timed_out) illegal <= 1'b1;
                    else                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                WR: begin
                    if (csr_ack) begin
                        if (csr_err) illegal <= 1'b1;
                    end else if (timed_out) illegal <= 1'b1;
                    else                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready    = (state == IDLE);
        csr_rd_en    = (state == RD);
        csr_wr_en    = (state == WR);
        rsp_valid    = (state == RESP);
        csr_addr     = op_addr;
        csr_wdata    = '0;
        if (state == WR) begin
            case (op_kind)
                2'b01:   csr_wdata = op_src;
                2'b10:   csr_wdata = old_value | op_src;
                default: csr_wdata = old_value & ~op_src;
            endcase
        end
        rsp_rd_idx   = op_rd;
        rsp_rd_value = old_value;
        rsp_illegal  = (state == RESP) && illegal;
        rsp_rd_we    = (state == RESP) && !illegal && (op_rd != 5'd0) && did_read;
    end

endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Scoreboard bench for csr_rmw_sequencer: reference model predicts bus strobes and responses,
// independent monitors pop and compare them as the DUT presents them.
module tb_csr_rmw_sequencer;
    localparam int XLEN = 32;
    localparam int T    = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_funct3 = '0;
    logic [11:0]     req_csr_addr = '0;
    logic [XLEN-1:0] req_rs1_value = '0;
    logic [4:0]      req_rs1_idx = '0;
    logic [4:0]      req_rd_idx = '0;
    logic [1:0]      req_priv = '0;
    logic            csr_rd_en;
    logic            csr_wr_en;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_ack = 1'b0;
    logic [XLEN-1:0] csr_rdata = '0;
    logic            csr_err = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [4:0]      rsp_rd_idx;
    logic            rsp_rd_we;
    logic [XLEN-1:0] rsp_rd_value;
    logic            rsp_illegal;

    csr_rmw_sequencer #(.XLEN(XLEN), .TIMEOUT_CYCS(T)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_value(req_rs1_value), .req_rs1_idx(req_rs1_idx),
        .req_rd_idx(req_rd_idx), .req_priv(req_priv),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_idx(rsp_rd_idx),
        .rsp_rd_we(rsp_rd_we), .rsp_rd_value(rsp_rd_value), .rsp_illegal(rsp_illegal)
    );

    always #5 clock = ~clock;

    typedef struct { int kind; logic [11:0] addr; logic [31:0] data; int len; } bus_t;
    typedef struct { logic illegal; logic rd_we; logic [4:0] rd; logic [31:0] val; } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    int          p_rd_delay = 0, p_wr_delay = 0;
    logic        p_rd_err = 1'b0, p_wr_err = 1'b0;
    logic [31:0] p_rdata = '0;

    int hold = 0, rsp_cnt = 0, rsp_cycle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // CSR file responder: acks after the planned number of strobe cycles, noise when idle.
    int r_kind = 0, r_cnt = 0;
    always @(negedge clock) begin : responder
        int k;
        k = csr_rd_en ? 1 : (csr_wr_en ? 2 : 0);
        if (k == 0) begin
            csr_ack   = ($urandom_range(0, 3) == 0);
            csr_err   = 1'($urandom_range(0, 1));
            csr_rdata = $urandom;
            r_cnt     = 0;
        end else begin
            if (k != r_kind) r_cnt = 0;
            else             r_cnt++;
            csr_ack   = (r_cnt == ((k == 1) ? p_rd_delay : p_wr_delay));
            csr_err   = (k == 1) ? p_rd_err : p_wr_err;
            csr_rdata = (csr_ack && k == 1) ? p_rdata : $urandom;
        end
        r_kind = k;
    end

    int   m_kind = 0, m_len = 0;
    bus_t m_cur;
    always @(negedge clock) begin : bus_monitor
        int k;
        if (csr_rd_en && csr_wr_en) check("strobe_exclusive", 1, 0);
        k = csr_rd_en ? 1 : (csr_wr_en ? 2 : 0);
        if (k != m_kind) begin
            if (m_kind != 0 && m_cur.len >= 0) check("strobe_len", 64'(m_len), 64'(m_cur.len));
            if (k != 0) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_strobe", 64'(k), 0);
                    m_cur.len = -1;
                end else begin
                    m_cur = exp_bus.pop_front();
                    check("strobe_kind", 64'(k), 64'(m_cur.kind));
                    check("csr_addr", 64'(csr_addr), 64'(m_cur.addr));
                    if (k == 2) check("csr_wdata", 64'(csr_wdata), 64'(m_cur.data));
                end
                m_len = 1;
            end
        end else if (k != 0) m_len++;
        m_kind = k;
    end

    logic prev_pend = 1'b0, prev_valid = 1'b0;
    rsp_t prev;
    always @(negedge clock) begin : rsp_monitor
        rsp_t e;
        if (rsp_valid && hold > 0) begin
            rsp_ready = 1'b0;
            hold--;
        end else rsp_ready = ($urandom_range(0, 3) != 0);
        if (rsp_valid && !prev_valid) rsp_cycle = cyc;
        if (rsp_valid) begin
            check("req_ready_in_resp", 64'(req_ready), 0);
            if (prev_pend) begin
                check("stable_illegal", 64'(rsp_illegal), 64'(prev.illegal));
                check("stable_rd_we", 64'(rsp_rd_we), 64'(prev.rd_we));
                check("stable_rd_idx", 64'(rsp_rd_idx), 64'(prev.rd));
                check("stable_rd_value", 64'(rsp_rd_value), 64'(prev.val));
            end
            if (rsp_ready) begin
                if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    e = exp_rsp.pop_front();
                    check("rsp_illegal", 64'(rsp_illegal), 64'(e.illegal));
                    check("rsp_rd_we", 64'(rsp_rd_we), 64'(e.rd_we));
                    check("rsp_rd_idx", 64'(rsp_rd_idx), 64'(e.rd));
                    if (!e.illegal) check("rsp_rd_value", 64'(rsp_rd_value), 64'(e.val));
                end
                rsp_cnt++;
            end
            prev = '{rsp_illegal, rsp_rd_we, rsp_rd_idx, rsp_rd_value};
        end
        prev_pend  = rsp_valid && !rsp_ready;
        prev_valid = rsp_valid;
    end

    function automatic int exp_len(input int delay);
        return (delay >= T) ? T : delay + 1;
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] v,
                         input logic [4:0] ri, input logic [4:0] rd, input logic [1:0] pv,
                         input int rdd, input logic rde, input logic [31:0] rdat,
                         input int wrd, input logic wre, input int lat);
        logic [31:0] src, old, wd;
        logic        bad, dor, dow, rdone;
        int          acc, start, guard;
        src   = f[2] ? {27'b0, ri} : v;
        dor   = !(f[1:0] == 2'b01 && rd == 5'd0);
        dow   = (f[1:0] == 2'b01) || (ri != 5'd0);
        bad   = (f[1:0] == 2'b00) || (a[9:8] > pv) || (dow && a[11:10] == 2'b11);
        old   = '0;
        rdone = 1'b0;
        if (!bad && dor) begin
            exp_bus.push_back('{1, a, 32'h0, exp_len(rdd)});
            if (rdd >= T || rde) bad = 1'b1;
            else begin
                old   = rdat;
                rdone = 1'b1;
            end
        end
        if (!bad && dow) begin
            case (f[1:0])
                2'b01:   wd = src;
                2'b10:   wd = old | src;
                default: wd = old & ~src;
            endcase
            exp_bus.push_back('{2, a, wd, exp_len(wrd)});
            if (wrd >= T || wre) bad = 1'b1;
        end
        exp_rsp.push_back('{bad, !bad && rd != 5'd0 && rdone, rd, old});
        p_rd_delay = rdd; p_rd_err = rde; p_rdata = rdat;
        p_wr_delay = wrd; p_wr_err = wre;

        @(negedge clock);
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) check("req_ready_wait", 0, 1);
        req_funct3 = f; req_csr_addr = a; req_rs1_value = v;
        req_rs1_idx = ri; req_rd_idx = rd; req_priv = pv;
        req_valid = 1'b1;
        acc   = cyc;
        start = rsp_cnt;
        @(posedge clock);
        #1;
        req_valid     = 1'b0;
        req_funct3    = 3'($urandom);
        req_csr_addr  = 12'($urandom);
        req_rs1_value = $urandom;
        req_rs1_idx   = 5'($urandom);
        req_rd_idx    = 5'($urandom);
        req_priv      = 2'($urandom);
        guard = 0;
        while (rsp_cnt == start && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (rsp_cnt == start) check("rsp_wait", 0, 1);
        else if (lat >= 0) check("latency", 64'(rsp_cycle - acc), 64'(lat));
    endtask

    function automatic int rand_delay();
        int s;
        s = int'($urandom_range(0, 9));
        if (s <= 5)      return int'($urandom_range(0, 3));
        else if (s == 6) return T - 1;
        else if (s == 7) return T;
        else if (s == 8) return T + 2;
        return 1;
    endfunction

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        logic [1:0] pv;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_req_ready", 64'(req_ready), 1);
        check("reset_rd_en", 64'(csr_rd_en), 0);
        check("reset_wr_en", 64'(csr_wr_en), 0);
        check("reset_rsp_valid", 64'(rsp_valid), 0);
        check("reset_addr", 64'(csr_addr), 0);
        check("reset_wdata", 64'(csr_wdata), 0);
        check("reset_rsp_fields", {rsp_rd_we, rsp_illegal, rsp_rd_idx, rsp_rd_value}, 0);
        reset = 1'b0;

        do_op(3'b010, 12'hC00, 32'hDEAD_BEEF, 5'd0, 5'd5, 2'd0, 0, 1'b0, 32'h1234, 0, 1'b0, 2);
        do_op(3'b011, 12'h300, 32'h0000_000F, 5'd7, 5'd3, 2'd3, 0, 1'b0, 32'hFF, 0, 1'b0, 3);
        do_op(3'b101, 12'h340, 32'h1234_5678, 5'd5, 5'd0, 2'd3, 0, 1'b0, 32'h0, 0, 1'b0, 2);
        do_op(3'b001, 12'hC01, 32'h1, 5'd1, 5'd1, 2'd3, 0, 1'b0, 32'h0, 0, 1'b0, 1);
        do_op(3'b001, 12'h300, 32'h1, 5'd1, 5'd1, 2'd0, 0, 1'b0, 32'h0, 0, 1'b0, 1);
        do_op(3'b100, 12'h300, 32'h1, 5'd1, 5'd1, 2'd3, 0, 1'b0, 32'h0, 0, 1'b0, 1);
        do_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd1, 2'd3, T, 1'b0, 32'h55, 0, 1'b0, T + 1);
        do_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd1, 2'd3, T - 1, 1'b0, 32'h55, 0, 1'b0, T + 1);
        do_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd2, 2'd3, 1, 1'b1, 32'h77, 0, 1'b0, -1);
        do_op(3'b001, 12'h300, 32'hA5, 5'd3, 5'd2, 2'd3, 0, 1'b0, 32'h77, 2, 1'b1, -1);
        do_op(3'b001, 12'h300, 32'hA5, 5'd3, 5'd2, 2'd3, 0, 1'b0, 32'h77, T, 1'b0, -1);
        do_op(3'b010, 12'h100, 32'h0F0, 5'd4, 5'd9, 2'd1, 0, 1'b0, 32'h00F, 0, 1'b0, 3);
        hold = 5;
        do_op(3'b110, 12'h305, 32'h0, 5'd12, 5'd7, 2'd3, 2, 1'b0, 32'h8000_0001, 1, 1'b0, -1);

        // Reset while a write strobe is pending: no response, no later strobe.
        exp_bus.push_back('{2, 12'h340, 32'h5, -1});
        p_wr_delay = 100; p_wr_err = 1'b0;
        @(negedge clock);
        req_funct3 = 3'b101; req_csr_addr = 12'h340; req_rs1_idx = 5'd5;
        req_rd_idx = 5'd0; req_priv = 2'd3; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!csr_wr_en && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("reset_test_wr_seen", 64'(csr_wr_en), 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midop_reset_wr_en", 64'(csr_wr_en), 0);
        check("midop_reset_rd_en", 64'(csr_rd_en), 0);
        check("midop_reset_rsp_valid", 64'(rsp_valid), 0);
        check("midop_reset_req_ready", 64'(req_ready), 1);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 2))
                0:       pv = 2'd0;
                1:       pv = 2'd1;
                default: pv = 2'd3;
            endcase
            do_op(3'($urandom), 12'($urandom),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  pv, rand_delay(), ($urandom_range(0, 7) == 0), $urandom,
                  rand_delay(), ($urandom_range(0, 7) == 0), -1);
        end

        repeat (5) @(negedge clock);
        check("bus_queue_drained", 64'(exp_bus.size()), 0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
